// File: rtl/memory_read_monitor.sv
// Access-checked read port over a 16x4 shadow memory with violation counting and a sticky alert.
// Define MRM_DENY_LOG_EN to build the last-denied-address/ID log registers.
module memory_read_monitor #(
  parameter int unsigned ALERT_THRESH = 3
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       rd_req,
  input  logic [3:0] rd_addr,
  input  logic [1:0] rd_module_id,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       alert_clr,
  output logic       rd_ack,
  output logic [3:0] rd_data,
  output logic       rd_denied,
  output logic       busy,
  output logic [3:0] viol_count,
  output logic       alert,
  output logic [3:0] last_deny_addr,
  output logic [1:0] last_deny_id
);

  localparam logic [3:0] THRESH = 4'(ALERT_THRESH);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t     state;
  logic [3:0] mem [16];
  logic [3:0] cap_addr;
  logic [1:0] cap_id;
  logic [3:0] word_q;
  logic       perm_q;
  logic       permit;
  logic       deny_now;
  logic [3:0] viol_next;
  logic       alert_next;

  always_comb begin
    permit = 1'b0;
    case (cap_addr[3:2])
      2'd0:    permit = 1'b1;
      2'd1:    permit = (cap_id == 2'd0) || (cap_id == 2'd1);
      2'd2:    permit = (cap_id == 2'd0) || (cap_id == 2'd2);
      default: permit = (cap_id == 2'd0);
    endcase
  end

  assign deny_now = (state == CHECK) && !permit;
  assign busy     = (state != IDLE);

  // A clear coincident with a violation restarts the count at 1, not 0.
  always_comb begin
    viol_next = viol_count;
    if (alert_clr)
      viol_next = deny_now ? 4'd1 : 4'd0;
    else if (deny_now && viol_count != 4'hF)
      viol_next = viol_count + 4'd1;
    alert_next = alert_clr ? (viol_next >= THRESH) : (alert || (viol_next >= THRESH));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      mem        <= '{default: '0};
      cap_addr   <= '0;
      cap_id     <= '0;
      word_q     <= '0;
      perm_q     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_data    <= '0;
      rd_denied  <= 1'b0;
      viol_count <= '0;
      alert      <= 1'b0;
    end else begin
      if (wr_en)
        mem[wr_addr] <= wr_data;
      viol_count <= viol_next;
      alert      <= alert_next;
      rd_ack     <= 1'b0;
      rd_data    <= '0;
      rd_denied  <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            cap_addr <= rd_addr;
            cap_id   <= rd_module_id;
            state    <= CHECK;
          end
        end
        CHECK: begin
          // Samples the pre-write word, so a write on this same edge is not seen.
          word_q <= mem[cap_addr];
          perm_q <= permit;
          state  <= RESP;
        end
        RESP: begin
          // Response is registered out of RESP: strobe is visible for the cycle after it.
          rd_ack    <= 1'b1;
          rd_data   <= perm_q ? word_q : 4'h0;
          rd_denied <= !perm_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MRM_DENY_LOG_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_deny_addr <= '0;
      last_deny_id   <= '0;
    end else if (deny_now) begin
      last_deny_addr <= cap_addr;
      last_deny_id   <= cap_id;
    end
  end
`else
  assign last_deny_addr = '0;
  assign last_deny_id   = '0;
`endif

endmodule

// File: tb/tb_memory_read_monitor.sv
// Self-checking bench for memory_read_monitor: cycle-indexed transaction model plus directed literal checks.
`timescale 1ns/1ps
module tb_memory_read_monitor;
  localparam int unsigned THRESH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [1:0] rd_id = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       alert_clr = 1'b0;
  logic       rd_ack, rd_denied, busy, alert;
  logic [3:0] rd_data, viol_count, last_deny_addr;
  logic [1:0] last_deny_id;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_read_monitor #(.ALERT_THRESH(THRESH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_module_id(rd_id), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alert_clr(alert_clr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_denied(rd_denied),
    .busy(busy), .viol_count(viol_count), .alert(alert),
    .last_deny_addr(last_deny_addr), .last_deny_id(last_deny_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic bit allowed(input logic [1:0] region, input logic [1:0] id);
    logic [15:0] tbl;
    tbl = 16'b0001_0101_0011_1111;
    return tbl[{region, id}];
  endfunction

  logic [3:0] m_mem [16];
  int         cyc = 0, free_at = 0, check_at = -1, ack_at = -1;
  logic [3:0] p_addr, p_word;
  logic [1:0] p_id;
  bit         p_ok;
  logic       e_ack, e_den, e_alert, e_busy;
  logic [3:0] e_data, e_viol, e_la;
  logic [1:0] e_li;
  bit         chk_en = 0;

  always @(posedge clk) begin
    bit den;
    den = 0;
    cyc++;
    if (rst) begin
      m_mem = '{default: 4'h0};
      free_at = cyc + 1; check_at = -1; ack_at = -1;
      e_ack = 0; e_den = 0; e_data = 0; e_viol = 0; e_alert = 0;
      e_la = 0; e_li = 0; e_busy = 0;
    end else begin
      e_ack = 0; e_den = 0; e_data = 0;
      if (cyc == check_at) begin
        p_ok   = allowed(p_addr[3:2], p_id);
        p_word = m_mem[p_addr];
        den    = !p_ok;
`ifdef MRM_DENY_LOG_EN
        if (den) begin e_la = p_addr; e_li = p_id; end
`endif
      end
      if (cyc == ack_at) begin
        e_ack = 1; e_den = !p_ok; e_data = p_ok ? p_word : 4'h0;
      end
      if (alert_clr) e_viol = den ? 4'd1 : 4'd0;
      else if (den && e_viol != 4'd15) e_viol++;
      if (e_viol >= THRESH) e_alert = 1;
      else if (alert_clr) e_alert = 0;
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (rd_req && cyc >= free_at) begin
        p_addr = rd_addr; p_id = rd_id;
        check_at = cyc + 1; ack_at = cyc + 2; free_at = cyc + 3;
      end
      e_busy = (cyc < ack_at);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_ack", rd_ack, e_ack);
      check("rd_data", rd_data, e_data);
      check("rd_denied", rd_denied, e_den);
      check("busy", busy, e_busy);
      check("viol_count", viol_count, e_viol);
      check("alert", alert, e_alert);
      check("last_deny_addr", last_deny_addr, e_la);
      check("last_deny_id", last_deny_id, e_li);
    end
  end

  // ---------------- stimulus helpers (enter/leave 1ns after a rising edge) ----------------
  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(posedge clk); #1 wr_en = 0;
  endtask

  task automatic wait_ack(output logic [3:0] d, output logic den, output int lat);
    bit got;
    got = 0; lat = 0; d = 'x; den = 'x;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (rd_ack) begin d = rd_data; den = rd_denied; got = 1; end
      else begin @(posedge clk); lat++; end
    end
    if (got) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [1:0] id,
                    output logic [3:0] d, output logic den, output int lat);
    rd_req = 1; rd_addr = a; rd_id = id;
    @(posedge clk); #1 rd_req = 0;
    wait_ack(d, den, lat);
  endtask

  task automatic clr_pulse();
    alert_clr = 1; @(posedge clk); #1 alert_clr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    logic       den;
    int         lat, acks, k1, k2;
    bit         saw;
    logic [15:0] deny_tbl;

    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    @(negedge clk);
    check("reset_ack", rd_ack, 0);
    check("reset_busy", busy, 0);
    check("reset_viol", viol_count, 0);
    check("reset_alert", alert, 0);
    @(posedge clk); #1;

    // permitted read: ID 1 in region 1
    wr(4'h5, 4'hC);
    rd(4'h5, 2'd1, d, den, lat);
    check("lat_permit", lat, 2);
    check("data_permit", d, 4'hC);
    check("den_permit", den, 0);
    check("viol_after_permit", viol_count, 0);

    // denied read: ID 3 in region 2
    wr(4'hA, 4'hF);
    rd(4'hA, 2'd3, d, den, lat);
    check("data_denied", d, 4'h0);
    check("den_denied", den, 1);
    check("viol_after_deny", viol_count, 1);
`ifdef MRM_DENY_LOG_EN
    check("log_addr", last_deny_addr, 4'hA);
    check("log_id", last_deny_id, 2'b11);
`else
    check("log_addr_tied", last_deny_addr, 4'h0);
`endif

    // alert on the third violation, then saturation, then clear
    clr_pulse();
    for (int i = 0; i < 3; i++) begin
      rd(4'hC, 2'd2, d, den, lat);
      check("viol_ramp", viol_count, i + 1);
      check("alert_ramp", alert, (i == 2));
    end
    repeat (14) rd(4'hC, 2'd2, d, den, lat);
    check("viol_saturate", viol_count, 15);
    check("alert_held", alert, 1);
    clr_pulse();
    @(negedge clk);
    check("viol_cleared", viol_count, 0);
    check("alert_cleared", alert, 0);
    @(posedge clk); #1;

    // rd_req held six sampled edges: two responses three cycles apart
    acks = 0; k1 = -1; k2 = -1;
    rd_req = 1; rd_addr = 4'h0; rd_id = 2'd0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 5) rd_req = 0;
      @(negedge clk);
      if (rd_ack) begin
        acks++;
        if (k1 < 0) k1 = k; else k2 = k;
      end
    end
    @(posedge clk); #1;
    check("held_ack_count", acks, 2);
    check("held_ack_spacing", k2 - k1, 3);

    // write on the CHECK edge is not seen by that read
    wr(4'h2, 4'h7);
    rd_req = 1; rd_addr = 4'h2; rd_id = 2'd0;
    @(posedge clk); #1 rd_req = 0;
    wr_en = 1; wr_addr = 4'h2; wr_data = 4'h3;
    @(posedge clk); #1 wr_en = 0;
    wait_ack(d, den, lat);
    check("rbw_old", d, 4'h7);
    rd(4'h2, 2'd0, d, den, lat);
    check("rbw_new", d, 4'h3);

    // clear coincident with a violation leaves count at 1
    rd(4'hC, 2'd1, d, den, lat);
    rd(4'hC, 2'd1, d, den, lat);
    check("viol_pre_coincident", viol_count, 2);
    rd_req = 1; rd_addr = 4'hC; rd_id = 2'd1;
    @(posedge clk); #1 rd_req = 0; alert_clr = 1;
    @(posedge clk); #1 alert_clr = 0;
    wait_ack(d, den, lat);
    check("coincident_den", den, 1);
    check("coincident_viol", viol_count, 1);
    check("coincident_alert", alert, 0);

    // policy sweep over all regions and IDs
    clr_pulse();
    deny_tbl = 16'b1110_1010_1100_0000;
    for (int r = 0; r < 4; r++) wr({2'(r), 2'b01}, 4'(9 + r));
    for (int r = 0; r < 4; r++) begin
      for (int id = 0; id < 4; id++) begin
        rd({2'(r), 2'b01}, 2'(id), d, den, lat);
        check("policy_den", den, deny_tbl[r * 4 + id]);
        check("policy_data", d, deny_tbl[r * 4 + id] ? 4'h0 : 4'(9 + r));
      end
    end
    check("policy_viol", viol_count, 7);
    check("policy_alert", alert, 1);

    // reset during CHECK aborts the read and clears memory
    rd_req = 1; rd_addr = 4'h2; rd_id = 2'd0;
    @(posedge clk); #1 rd_req = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    saw = 0;
    for (int k = 0; k < 4; k++) begin
      if (rd_ack) saw = 1;
      @(negedge clk);
    end
    check("abort_no_ack", saw, 0);
    check("abort_viol", viol_count, 0);
    check("abort_alert", alert, 0);
    @(posedge clk); #1;
    rd(4'h2, 2'd0, d, den, lat);
    check("mem_cleared", d, 4'h0);
    check("mem_cleared_den", den, 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
